// File: rtl/multicycle_mips_controller.sv
// Moore control FSM for the multicycle MIPS datapath: 3-5 states per instruction,
// outputs decoded combinationally from the state register (BR PCLoad also uses i_zero).
module multicycle_mips_controller (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funccode,
    input  logic       i_zero,
    output logic [2:0] o_ALUOperation,
    output logic [1:0] o_PCSrc,
    output logic [1:0] o_ALUSrcB,
    output logic       o_ALUSrcA,
    output logic       o_PCLoad,
    output logic       o_IRWrite,
    output logic       o_IorD,
    output logic       o_MemRead,
    output logic       o_MemWrite,
    output logic       o_MemtoReg,
    output logic       o_RegDst,
    output logic       o_lastReg,
    output logic       o_PCtoReg,
    output logic       o_RegWrite,
    output logic [3:0] o_state,
    output logic       o_illegal
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_REX    = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BR     = 4'd8;
    localparam logic [3:0] S_IEX    = 4'd9;
    localparam logic [3:0] S_IWB    = 4'd10;
    localparam logic [3:0] S_J      = 4'd11;
    localparam logic [3:0] S_JAL    = 4'd12;
    localparam logic [3:0] S_JR     = 4'd13;
    localparam logic [3:0] S_ERR    = 4'd14;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_rtype_alu;

    logic [2:0] w_aluop;
    logic [1:0] w_pcsrc;
    logic [1:0] w_srcb;
    logic       w_srca;
    logic       w_pcload;
    logic       w_irwrite;
    logic       w_iord;
    logic       w_memread;
    logic       w_memwrite;
    logic       w_memtoreg;
    logic       w_regdst;
    logic       w_lastreg;
    logic       w_pctoreg;
    logic       w_regwrite;
    logic       w_illegal;

    assign w_rtype_alu = (i_funccode == FN_ADD) || (i_funccode == FN_SUB) ||
                         (i_funccode == FN_AND) || (i_funccode == FN_OR)  ||
                         (i_funccode == FN_SLT);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_ERR;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (i_opcode)
                    OP_RTYPE: begin
                        if (w_rtype_alu)              w_next = S_REX;
                        else if (i_funccode == FN_JR) w_next = S_JR;
                        else                          w_next = S_ERR;
                    end
                    OP_LW, OP_SW:     w_next = S_MEMADR;
                    OP_BEQ, OP_BNE:   w_next = S_BR;
                    OP_ADDI, OP_SLTI: w_next = S_IEX;
                    OP_J:             w_next = S_J;
                    OP_JAL:           w_next = S_JAL;
                    default:          w_next = S_ERR;
                endcase
            end
            // IR is held, so the opcode still selects load versus store here
            S_MEMADR: begin
                if (i_opcode == OP_LW)      w_next = S_MEMRD;
                else if (i_opcode == OP_SW) w_next = S_MEMWR;
                else                        w_next = S_ERR;
            end
            S_MEMRD:  w_next = S_MEMWB;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = S_FETCH;
            S_REX:    w_next = S_RWB;
            S_RWB:    w_next = S_FETCH;
            S_BR:     w_next = S_FETCH;
            S_IEX:    w_next = S_IWB;
            S_IWB:    w_next = S_FETCH;
            S_J:      w_next = S_FETCH;
            S_JAL:    w_next = S_FETCH;
            S_JR:     w_next = S_FETCH;
            S_ERR:    w_next = S_ERR;
            default:  w_next = S_ERR;
        endcase
    end

    always_comb begin
        w_aluop    = 3'b000;
        w_pcsrc    = 2'b00;
        w_srcb     = 2'b00;
        w_srca     = 1'b0;
        w_pcload   = 1'b0;
        w_irwrite  = 1'b0;
        w_iord     = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_regdst   = 1'b0;
        w_lastreg  = 1'b0;
        w_pctoreg  = 1'b0;
        w_regwrite = 1'b0;
        w_illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                w_irwrite = 1'b1;
                w_pcload  = 1'b1;
                w_srcb    = 2'b01;
                w_aluop   = ALU_ADD;
            end
            S_DECODE: begin
                w_srcb  = 2'b11;
                w_aluop = ALU_ADD;
            end
            S_MEMADR: begin
                w_srca  = 1'b1;
                w_srcb  = 2'b10;
                w_aluop = ALU_ADD;
            end
            S_MEMRD: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
            end
            S_MEMWR: begin
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
            end
            S_REX: begin
                w_srca = 1'b1;
                case (i_funccode)
                    FN_SUB:  w_aluop = ALU_SUB;
                    FN_AND:  w_aluop = ALU_AND;
                    FN_OR:   w_aluop = ALU_OR;
                    FN_SLT:  w_aluop = ALU_SLT;
                    default: w_aluop = ALU_ADD;
                endcase
            end
            S_RWB: begin
                w_regwrite = 1'b1;
                w_regdst   = 1'b1;
            end
            // Branch target was computed into ALURes during DECODE
            S_BR: begin
                w_srca   = 1'b1;
                w_aluop  = ALU_SUB;
                w_pcsrc  = 2'b10;
                w_pcload = (i_opcode == OP_BNE) ? ~i_zero : i_zero;
            end
            S_IEX: begin
                w_srca  = 1'b1;
                w_srcb  = 2'b10;
                w_aluop = (i_opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_IWB: begin
                w_regwrite = 1'b1;
            end
            S_J: begin
                w_pcsrc  = 2'b01;
                w_pcload = 1'b1;
            end
            S_JAL: begin
                w_pcsrc    = 2'b01;
                w_pcload   = 1'b1;
                w_regwrite = 1'b1;
                w_lastreg  = 1'b1;
                w_pctoreg  = 1'b1;
            end
            S_JR: begin
                w_pcsrc  = 2'b11;
                w_pcload = 1'b1;
            end
            S_ERR: begin
                w_illegal = 1'b1;
            end
            default: begin
                w_illegal = 1'b0;
            end
        endcase
    end

    // Outputs are gated by reset so a write in flight is cut off the moment reset falls
    assign o_ALUOperation = i_rst ? w_aluop : 3'b000;
    assign o_PCSrc        = i_rst ? w_pcsrc : 2'b00;
    assign o_ALUSrcB      = i_rst ? w_srcb  : 2'b00;
    assign o_ALUSrcA      = i_rst & w_srca;
    assign o_PCLoad       = i_rst & w_pcload;
    assign o_IRWrite      = i_rst & w_irwrite;
    assign o_IorD         = i_rst & w_iord;
    assign o_MemRead      = i_rst & w_memread;
    assign o_MemWrite     = i_rst & w_memwrite;
    assign o_MemtoReg     = i_rst & w_memtoreg;
    assign o_RegDst       = i_rst & w_regdst;
    assign o_lastReg      = i_rst & w_lastreg;
    assign o_PCtoReg      = i_rst & w_pctoreg;
    assign o_RegWrite     = i_rst & w_regwrite;
    assign o_state        = i_rst ? r_state : 4'd0;
    assign o_illegal      = i_rst & w_illegal;

endmodule

// File: tb/tb_multicycle_mips_controller.sv
// Directed bench for the multicycle MIPS controller; expected output vectors are queued
// by the stimulus process and compared by an independent monitor.
module tb_multicycle_mips_controller;

    logic       i_clk;
    logic       i_rst;
    logic [5:0] i_opcode;
    logic [5:0] i_funccode;
    logic       i_zero;
    logic [2:0] o_ALUOperation;
    logic [1:0] o_PCSrc;
    logic [1:0] o_ALUSrcB;
    logic       o_ALUSrcA;
    logic       o_PCLoad;
    logic       o_IRWrite;
    logic       o_IorD;
    logic       o_MemRead;
    logic       o_MemWrite;
    logic       o_MemtoReg;
    logic       o_RegDst;
    logic       o_lastReg;
    logic       o_PCtoReg;
    logic       o_RegWrite;
    logic [3:0] o_state;
    logic       o_illegal;

    logic        tb_probe;
    logic [22:0] exp_q[$];
    string       nm_q[$];
    int          checks;
    int          failures;
    logic        done;

    multicycle_mips_controller dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_opcode       (i_opcode),
        .i_funccode     (i_funccode),
        .i_zero         (i_zero),
        .o_ALUOperation (o_ALUOperation),
        .o_PCSrc        (o_PCSrc),
        .o_ALUSrcB      (o_ALUSrcB),
        .o_ALUSrcA      (o_ALUSrcA),
        .o_PCLoad       (o_PCLoad),
        .o_IRWrite      (o_IRWrite),
        .o_IorD         (o_IorD),
        .o_MemRead      (o_MemRead),
        .o_MemWrite     (o_MemWrite),
        .o_MemtoReg     (o_MemtoReg),
        .o_RegDst       (o_RegDst),
        .o_lastReg      (o_lastReg),
        .o_PCtoReg      (o_PCtoReg),
        .o_RegWrite     (o_RegWrite),
        .o_state        (o_state),
        .o_illegal      (o_illegal)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Control word: PCLoad IRWrite IorD MemRead MemWrite MemtoReg RegDst lastReg PCtoReg RegWrite
    function automatic logic [22:0] ev(input logic [3:0] st, input logic ill, input logic [2:0] op,
                                       input logic [1:0] pcs, input logic [1:0] sb,
                                       input logic sa, input logic [9:0] c);
        return {st, ill, op, pcs, sb, sa, c};
    endfunction

    logic [22:0] E_RST, E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_MEMWR;
    logic [22:0] E_REX_SUB, E_REX_ADD, E_RWB, E_BR_T, E_BR_N, E_IEX_ADD, E_IEX_SLT;
    logic [22:0] E_IWB, E_J, E_JAL, E_JR, E_ERR;

    initial begin
        E_RST     = ev(4'd0,  1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 10'b0000000000);
        E_FETCH   = ev(4'd0,  1'b0, 3'b010, 2'b00, 2'b01, 1'b0, 10'b1101000000);
        E_DECODE  = ev(4'd1,  1'b0, 3'b010, 2'b00, 2'b11, 1'b0, 10'b0000000000);
        E_MEMADR  = ev(4'd2,  1'b0, 3'b010, 2'b00, 2'b10, 1'b1, 10'b0000000000);
        E_MEMRD   = ev(4'd3,  1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 10'b0011000000);
        E_MEMWB   = ev(4'd4,  1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 10'b0000010001);
        E_MEMWR   = ev(4'd5,  1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 10'b0010100000);
        E_REX_SUB = ev(4'd6,  1'b0, 3'b011, 2'b00, 2'b00, 1'b1, 10'b0000000000);
        E_REX_ADD = ev(4'd6,  1'b0, 3'b010, 2'b00, 2'b00, 1'b1, 10'b0000000000);
        E_RWB     = ev(4'd7,  1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 10'b0000001001);
        E_BR_T    = ev(4'd8,  1'b0, 3'b011, 2'b10, 2'b00, 1'b1, 10'b1000000000);
        E_BR_N    = ev(4'd8,  1'b0, 3'b011, 2'b10, 2'b00, 1'b1, 10'b0000000000);
        E_IEX_ADD = ev(4'd9,  1'b0, 3'b010, 2'b00, 2'b10, 1'b1, 10'b0000000000);
        E_IEX_SLT = ev(4'd9,  1'b0, 3'b100, 2'b00, 2'b10, 1'b1, 10'b0000000000);
        E_IWB     = ev(4'd10, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 10'b0000000001);
        E_J       = ev(4'd11, 1'b0, 3'b000, 2'b01, 2'b00, 1'b0, 10'b1000000000);
        E_JAL     = ev(4'd12, 1'b0, 3'b000, 2'b01, 2'b00, 1'b0, 10'b1000000111);
        E_JR      = ev(4'd13, 1'b0, 3'b000, 2'b11, 2'b00, 1'b0, 10'b1000000000);
        E_ERR     = ev(4'd14, 1'b1, 3'b000, 2'b00, 2'b00, 1'b0, 10'b0000000000);
    end

    function automatic logic [22:0] dut_vec();
        return {o_state, o_illegal, o_ALUOperation, o_PCSrc, o_ALUSrcB, o_ALUSrcA,
                o_PCLoad, o_IRWrite, o_IorD, o_MemRead, o_MemWrite, o_MemtoReg,
                o_RegDst, o_lastReg, o_PCtoReg, o_RegWrite};
    endfunction

    // Monitor: samples mid-cycle, or on an explicit probe for asynchronous events
    always @(negedge i_clk or posedge tb_probe) begin
        if (exp_q.size() > 0) begin
            logic [22:0] e;
            logic [22:0] g;
            string       n;
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            g = dut_vec();
            checks = checks + 1;
            if (g !== e) begin
                failures = failures + 1;
                $display("FAIL %s got=%06h exp=%06h (state got=%0d exp=%0d)",
                         n, g, e, g[22:19], e[22:19]);
            end
            if (o_MemRead === 1'b1 && o_MemWrite === 1'b1) begin
                failures = failures + 1;
                $display("FAIL %s_memrw_excl got=MemRead&MemWrite exp=not_both", n);
            end
        end
    end

    task automatic cyc(input logic [22:0] e, input string nm);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
        i_opcode   = op;
        i_funccode = fn;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        done     = 1'b0;
        tb_probe = 1'b0;
        i_rst    = 1'b0;
        i_zero   = 1'b0;
        set_ir(6'b100011, 6'b000000);
        @(posedge i_clk);
        #1;
        cyc(E_RST, "reset_hold0");
        cyc(E_RST, "reset_hold1");

        i_rst = 1'b1;
        cyc(E_FETCH,  "lw_fetch");
        cyc(E_DECODE, "lw_decode");
        cyc(E_MEMADR, "lw_memadr");
        cyc(E_MEMRD,  "lw_memrd");
        cyc(E_MEMWB,  "lw_memwb");

        set_ir(6'b000000, 6'b100010);
        cyc(E_FETCH,   "sub_fetch");
        cyc(E_DECODE,  "sub_decode");
        cyc(E_REX_SUB, "sub_rex");
        cyc(E_RWB,     "sub_rwb");

        set_ir(6'b000000, 6'b100000);
        cyc(E_FETCH,   "add_fetch");
        cyc(E_DECODE,  "add_decode");
        cyc(E_REX_ADD, "add_rex");
        cyc(E_RWB,     "add_rwb");

        set_ir(6'b000100, 6'b000000);
        i_zero = 1'b0;
        cyc(E_FETCH,  "beq1_fetch");
        cyc(E_DECODE, "beq1_decode");
        i_zero = 1'b1;
        cyc(E_BR_T,   "beq_z1_br");

        cyc(E_FETCH,  "beq0_fetch");
        cyc(E_DECODE, "beq0_decode");
        i_zero = 1'b0;
        cyc(E_BR_N,   "beq_z0_br");

        set_ir(6'b000101, 6'b000000);
        i_zero = 1'b0;
        cyc(E_FETCH,  "bne1_fetch");
        cyc(E_DECODE, "bne1_decode");
        i_zero = 1'b1;
        cyc(E_BR_N,   "bne_z1_br");

        i_zero = 1'b1;
        cyc(E_FETCH,  "bne0_fetch");
        cyc(E_DECODE, "bne0_decode");
        i_zero = 1'b0;
        cyc(E_BR_T,   "bne_z0_br");

        set_ir(6'b001000, 6'b000000);
        cyc(E_FETCH,   "addi_fetch");
        cyc(E_DECODE,  "addi_decode");
        cyc(E_IEX_ADD, "addi_iex");
        cyc(E_IWB,     "addi_iwb");

        set_ir(6'b001010, 6'b000000);
        cyc(E_FETCH,   "slti_fetch");
        cyc(E_DECODE,  "slti_decode");
        cyc(E_IEX_SLT, "slti_iex");
        cyc(E_IWB,     "slti_iwb");

        set_ir(6'b000010, 6'b000000);
        cyc(E_FETCH,  "j_fetch");
        cyc(E_DECODE, "j_decode");
        cyc(E_J,      "j_j");

        set_ir(6'b000011, 6'b000000);
        cyc(E_FETCH,  "jal_fetch");
        cyc(E_DECODE, "jal_decode");
        cyc(E_JAL,    "jal_jal");

        set_ir(6'b000000, 6'b001000);
        cyc(E_FETCH,  "jr_fetch");
        cyc(E_DECODE, "jr_decode");
        cyc(E_JR,     "jr_jr");

        set_ir(6'b101011, 6'b000000);
        cyc(E_FETCH,  "sw_fetch");
        cyc(E_DECODE, "sw_decode");
        cyc(E_MEMADR, "sw_memadr");
        cyc(E_MEMWR,  "sw_memwr");

        // Second store: reset lands in the second half of MEMWR
        cyc(E_FETCH,  "sw2_fetch");
        cyc(E_DECODE, "sw2_decode");
        cyc(E_MEMADR, "sw2_memadr");
        exp_q.push_back(E_MEMWR);
        nm_q.push_back("sw2_memwr");
        @(negedge i_clk);
        #1;
        i_rst = 1'b0;
        #1;
        exp_q.push_back(E_RST);
        nm_q.push_back("sw2_async_reset");
        tb_probe = 1'b1;
        #1;
        tb_probe = 1'b0;
        @(posedge i_clk);
        #1;
        cyc(E_RST, "sw2_reset_held");
        i_rst = 1'b1;
        set_ir(6'b111111, 6'b000000);
        cyc(E_FETCH,  "ill_op_fetch");
        cyc(E_DECODE, "ill_op_decode");
        for (int k = 0; k < 12; k++) begin
            cyc(E_ERR, $sformatf("ill_op_err%0d", k));
        end

        i_rst = 1'b0;
        cyc(E_RST, "ill_op_reset");
        i_rst = 1'b1;
        set_ir(6'b000000, 6'b000111);
        cyc(E_FETCH,  "ill_fn_fetch");
        cyc(E_DECODE, "ill_fn_decode");
        cyc(E_ERR,    "ill_fn_err0");
        cyc(E_ERR,    "ill_fn_err1");
        i_rst = 1'b0;
        cyc(E_RST, "ill_fn_reset");
        i_rst = 1'b1;
        set_ir(6'b000010, 6'b000000);
        cyc(E_FETCH,  "post_err_fetch");
        cyc(E_DECODE, "post_err_decode");

        @(negedge i_clk);
        #1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog got=timeout exp=finish");
            $fatal(1, "watchdog expired");
        end
    end

endmodule
